// File: rtl/matrix_kbd_scanner_if.sv
// Keyboard scanner bus: row drive / column sense toward the key matrix and
// the status word plus acknowledge toward the CPU register file.
//
// Handshake: the scanner raises key_event for exactly one cycle when a new
// press is accepted and sets keyboard[31] (pending). The consumer answers with
// a one-cycle kb_ack pulse; pending and overrun clear on the following cycle.
// There is no back-pressure: a press accepted while pending is still set
// overwrites the code and raises overrun.
interface matrix_kbd_scanner_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4
);
  logic [ROWS-1:0] row_o;       // active-low row drive
  logic [COLS-1:0] col_i;       // active-low column sense, asynchronous
  logic            kb_ack;      // consumer took the pending key
  logic [31:0]     keyboard;    // status word
  logic            key_event;   // new press accepted
  logic            scan_state;  // debug: 1 while in the SAMPLE state

  // Scanner side
  modport master (
    output row_o, keyboard, key_event, scan_state,
    input  col_i, kb_ack
  );

  // Matrix / CPU side
  modport slave (
    input  row_o, keyboard, key_event, scan_state,
    output col_i, kb_ack
  );
endinterface

// File: rtl/matrix_kbd_scanner.sv
// Matrix keyboard scanner with frame-level debounce.
// One row at a time is pulled low, given SETTLE_CYCLES to settle, then the
// synchronized columns are captured. After the last row the whole frame is
// reduced to the lowest pressed key index; that candidate must hold for
// DEBOUNCE_SCANS consecutive frames before the debounced state changes.
module matrix_kbd_scanner #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SETTLE_CYCLES  = 500,
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  matrix_kbd_scanner_if.master bus
);

  localparam int NKEYS = ROWS * COLS;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW    = $clog2(SETTLE_CYCLES + 1);
  localparam int SW    = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic {
    SETTLE = 1'b0,
    SAMPLE = 1'b1
  } scan_state_t;

  // Column synchronizer
  logic [COLS-1:0]  col_meta;
  logic [COLS-1:0]  col_sync;

  // Scan FSM
  scan_state_t      state;
  logic             running;
  logic [RW-1:0]    row_idx;
  logic [RW-1:0]    row_next;
  logic [CW-1:0]    settle_cnt;
  logic [ROWS-1:0]  row_drive;

  // Frame capture and candidate
  logic [NKEYS-1:0] frame_buf;
  logic [NKEYS-1:0] frame_now;
  logic             cand_v;
  logic [4:0]       cand;
  logic             frame_end;

  // Debounce
  logic             last_v;
  logic [4:0]       last_c;
  logic [SW-1:0]    stable_cnt;
  logic [SW-1:0]    stable_next;
  logic             deb_v;
  logic [4:0]       deb_c;
  logic             accept;
  logic             press;

  // Key status
  logic             pending;
  logic             overrun;
  logic             key_down;
  logic [4:0]       code;
  logic             key_event_r;

  // Two-flop synchronizer; idle columns read high, so reset to all ones
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_meta <= '1;
      col_sync <= '1;
    end else begin
      col_meta <= bus.col_i;
      col_sync <= col_meta;
    end
  end

  // Next row index, wrapping after the last row
  always_comb begin
    row_next = row_idx + RW'(1);
    if (row_idx == RW'(ROWS - 1)) begin
      row_next = '0;
    end
  end

  // Scan FSM: settle a row, sample it once, move to the next row.
  // The cycle after reset only starts driving row 0, so that row 0 gets its
  // full SETTLE_CYCLES+1 cycles like every other row.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= SETTLE;
      running    <= 1'b0;
      row_idx    <= '0;
      settle_cnt <= '0;
      row_drive  <= '1;
    end else if (!running) begin
      running   <= 1'b1;
      row_drive <= ~(ROWS'(1));
    end else begin
      case (state)
        SETTLE: begin
          if (settle_cnt == CW'(SETTLE_CYCLES - 1)) begin
            state      <= SAMPLE;
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + CW'(1);
          end
        end
        SAMPLE: begin
          state     <= SETTLE;
          row_idx   <= row_next;
          row_drive <= ~(ROWS'(1) << row_next);
        end
        default: begin
          state <= SETTLE;
        end
      endcase
    end
  end

  // Capture the pressed keys of the row being sampled (columns are active-low)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_buf <= '0;
    end else if (state == SAMPLE) begin
      frame_buf[row_idx*COLS +: COLS] <= ~col_sync;
    end
  end

  // Complete frame as seen on the last row's sample cycle, including that row
  always_comb begin
    frame_now = frame_buf;
    frame_now[(ROWS-1)*COLS +: COLS] = ~col_sync;
  end

  // Lowest pressed key index in row-major order
  always_comb begin
    cand_v = |frame_now;
    cand   = '0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (frame_now[i]) begin
        cand = 5'(i);
      end
    end
  end

  // Debounce decision for the frame completing this cycle
  always_comb begin
    frame_end   = (state == SAMPLE) && (row_idx == RW'(ROWS - 1));
    stable_next = '0;
    if ({cand_v, cand} == {last_v, last_c}) begin
      if (stable_cnt == SW'(DEBOUNCE_SCANS - 1)) begin
        stable_next = stable_cnt;
      end else begin
        stable_next = stable_cnt + SW'(1);
      end
    end
    accept = frame_end
          && (stable_next == SW'(DEBOUNCE_SCANS - 1))
          && ({cand_v, cand} != {deb_v, deb_c});
    press  = accept && cand_v;
  end

  // Frame history and debounced state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_v     <= 1'b0;
      last_c     <= '0;
      stable_cnt <= '0;
      deb_v      <= 1'b0;
      deb_c      <= '0;
    end else if (frame_end) begin
      last_v     <= cand_v;
      last_c     <= cand;
      stable_cnt <= stable_next;
      if (accept) begin
        deb_v <= cand_v;
        deb_c <= cand;
      end
    end
  end

  // Status word: a press wins over a simultaneous ack (the new key stays
  // pending) but the ack still suppresses overrun for that press
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending     <= 1'b0;
      overrun     <= 1'b0;
      key_down    <= 1'b0;
      code        <= '0;
      key_event_r <= 1'b0;
    end else begin
      key_event_r <= press;
      if (accept) begin
        key_down <= cand_v;
      end
      if (press) begin
        code    <= cand;
        pending <= 1'b1;
        overrun <= pending && !bus.kb_ack;
      end else if (bus.kb_ack) begin
        pending <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

  assign bus.row_o      = row_drive;
  assign bus.keyboard   = {pending, overrun, 21'b0, key_down, 3'b0, code};
  assign bus.key_event  = key_event_r;
  assign bus.scan_state = (state == SAMPLE);

endmodule

// File: tb/tb_matrix_kbd_scanner.sv
// Bench for matrix_kbd_scanner: 4x4 matrix, 4 settle cycles, 3-frame debounce
// (20-cycle frames). An ideal key matrix pulls a column low whenever its
// driven row crosses a held key.
module tb_matrix_kbd_scanner;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int SETTLE = 4;
  localparam int DEB   = 3;
  localparam int FRAME = ROWS * (SETTLE + 1);

  typedef struct {
    logic [15:0] keys;
    int          hold;
    bit          ack;
    logic [31:0] exp_kb;
    int          exp_ev;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] keys = '0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_events = 0;
  vec_t        tbl [12];

  matrix_kbd_scanner_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  matrix_kbd_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SETTLE_CYCLES(SETTLE), .DEBOUNCE_SCANS(DEB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock
  always #5 clk = ~clk;

  // Ideal key matrix
  always_comb begin
    bus.col_i = '1;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (!bus.row_o[r] && keys[r*COLS+c]) begin
          bus.col_i[c] = 1'b0;
        end
      end
    end
  end

  // Count key_event pulses shortly after each active edge
  always @(posedge clk) begin
    #1;
    if (bus.key_event === 1'b1) n_events++;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Hold a key set, optionally pulse kb_ack at the end; report events seen
  task automatic apply_seg(input logic [15:0] k, input int hold, input bit ack, output int ev);
    int e0;
    keys = k;
    e0 = n_events;
    repeat (hold) @(negedge clk);
    if (ack) begin
      bus.kb_ack = 1'b1;
      @(negedge clk);
      bus.kb_ack = 1'b0;
    end
    ev = n_events - e0;
  endtask

  // Wait for the first cycle of a frame (row 3 just handed over to row 0)
  task automatic sync_frame_start(output bit ok);
    logic [3:0] prev;
    ok = 1'b0;
    prev = bus.row_o;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (prev == 4'h7 && bus.row_o == 4'hE) begin
        ok = 1'b1;
        break;
      end
      prev = bus.row_o;
    end
  endtask

  initial begin
    int          ev;
    int          e0;
    bit          ok;
    bit          seen;
    logic [15:0] k;
    int          nk;
    int          hold;
    bit          ack;
    bit          mv;
    logic [4:0]  mc;
    bit          m_v, m_pend, m_ovr, m_down;
    logic [4:0]  m_c, m_code;

    tbl[0]  = '{16'h0200, 120, 1'b0, 32'h8000_0109, 1};
    tbl[1]  = '{16'h0000,  90, 1'b0, 32'h8000_0009, 0};
    tbl[2]  = '{16'h0000,  10, 1'b1, 32'h0000_0009, 0};
    tbl[3]  = '{16'h0220, 120, 1'b0, 32'h8000_0105, 1};
    tbl[4]  = '{16'h0000, 100, 1'b1, 32'h0000_0005, 0};
    tbl[5]  = '{16'h0200, 120, 1'b0, 32'h8000_0109, 1};
    tbl[6]  = '{16'h0000, 100, 1'b0, 32'h8000_0009, 0};
    tbl[7]  = '{16'h0004, 120, 1'b0, 32'hC000_0102, 1};
    tbl[8]  = '{16'h0004,  10, 1'b1, 32'h0000_0102, 0};
    tbl[9]  = '{16'h0000, 100, 1'b0, 32'h0000_0002, 0};
    tbl[10] = '{16'h0200, 120, 1'b0, 32'h8000_0109, 1};
    tbl[11] = '{16'h0000, 100, 1'b0, 32'h8000_0009, 0};

    // Reset block
    bus.kb_ack = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Build up state, then reset in the middle of a scan
    apply_seg(16'h0200, 120, 1'b0, ev);
    check("pre-reset keyboard", bus.keyboard, 32'h8000_0109);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check("reset row_o", bus.row_o, 4'hF);
    check("reset keyboard", bus.keyboard, 32'h0);
    check("reset key_event", bus.key_event, 1'b0);
    check("reset scan_state", bus.scan_state, 1'b0);
    keys = '0;
    rst_n = 1'b1;
    for (int i = 0; i < SETTLE + 1; i++) begin
      @(negedge clk);
      check($sformatf("row0 cycle %0d", i), bus.row_o, 4'hE);
    end
    @(negedge clk);
    check("row1 start", bus.row_o, 4'hD);

    // Table-driven press / release / ack vectors
    for (int i = 0; i < 12; i++) begin
      apply_seg(tbl[i].keys, tbl[i].hold, tbl[i].ack, ev);
      check($sformatf("vec%0d keyboard", i), bus.keyboard, tbl[i].exp_kb);
      check($sformatf("vec%0d events", i), ev, tbl[i].exp_ev);
    end

    // Ack coinciding with an accepted press of key 7 while pending=1
    sync_frame_start(ok);
    check("frame sync", ok, 1'b1);
    keys = 16'h0080;
    e0 = n_events;
    repeat (3 * FRAME - 1) @(negedge clk);
    check("same-cycle ack early events", n_events - e0, 0);
    bus.kb_ack = 1'b1;
    @(negedge clk);
    bus.kb_ack = 1'b0;
    check("same-cycle ack key_event", bus.key_event, 1'b1);
    check("same-cycle ack keyboard", bus.keyboard, 32'h8000_0107);
    apply_seg(16'h0000, 100, 1'b1, ev);
    check("release key7 keyboard", bus.keyboard, 32'h0000_0007);
    check("release key7 events", ev, 0);

    // Bouncing contact on key (0,3), then held
    e0 = n_events;
    for (int i = 0; i < 80; i++) begin
      keys = (((i / 7) % 2) == 0) ? 16'h0008 : 16'h0000;
      @(negedge clk);
    end
    check("bounce events", n_events - e0, 0);
    keys = 16'h0008;
    e0 = n_events;
    seen = 1'b0;
    for (int i = 0; i < 4 * FRAME + 3; i++) begin
      @(negedge clk);
      if (n_events > e0) seen = 1'b1;
    end
    check("bounce settle event in time", seen, 1'b1);
    repeat (40) @(negedge clk);
    check("bounce total events", n_events - e0, 1);
    check("bounce status", {bus.keyboard[31], bus.keyboard[8], bus.keyboard[4:0]}, {1'b1, 1'b1, 5'd3});
    apply_seg(16'h0000, 100, 1'b1, ev);
    check("bounce release keyboard", bus.keyboard, 32'h0000_0003);

    // Randomized key sets against a segment-level model
    m_v = 1'b0; m_c = '0; m_pend = 1'b0; m_ovr = 1'b0; m_down = 1'b0; m_code = 5'd3;
    for (int s = 0; s < 30; s++) begin
      nk = $urandom_range(0, 2);
      k = '0;
      for (int j = 0; j < nk; j++) k[$urandom_range(0, 15)] = 1'b1;
      hold = $urandom_range(100, 140);
      ack = 1'($urandom_range(0, 1));
      mv = 1'b0;
      mc = '0;
      for (int idx = 0; idx < 16; idx++) begin
        if (k[idx] && !mv) begin
          mv = 1'b1;
          mc = 5'(idx);
        end
      end
      e0 = 0;
      if ({mv, mc} != {m_v, m_c}) begin
        m_v = mv;
        m_c = mc;
        m_down = mv;
        if (mv) begin
          e0 = 1;
          m_ovr = m_pend;
          m_pend = 1'b1;
          m_code = mc;
        end
      end
      if (ack) begin
        m_pend = 1'b0;
        m_ovr = 1'b0;
      end
      apply_seg(k, hold, ack, ev);
      check($sformatf("rand%0d keyboard", s), bus.keyboard,
            {m_pend, m_ovr, 21'b0, m_down, 3'b0, m_code});
      check($sformatf("rand%0d events", s), ev, e0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
